commit_ctrl: RTL and testbench
==============================

// Module: commit_ctrl
// PURPOSE
// In-order retirement controller for the reorder buffer; sits between the ROB head and the architectural state.
// Each cycle it inspects the head and decides whether to retire it:
//   - register write for ALU/load results
//   - store release to the LSQ
//   - branch redirect with pipeline flush on mispredict
//   - trap entry on exception
// It drives the ROB dequeue strobe and the illegal-access flag back into the ROB.
// PARAMETERS
// XLEN          32  data/address width
// ROB_IDX_W     4   ROB tag width; tag 0 is reserved for "no entry"
// FLUSH_CYCLES  2   cycles flush is held after a mispredict or trap (>=1)
// PORTS
// clk               in   1          clock
// reset             in   1          synchronous, active-high
// rob_empty         in   1          ROB empty status
// head_ready        in   1          head result valid
// head_itype        in   2          00 branch, 01 store, 1x reg-dest/load
// head_rob_num      in   ROB_IDX_W  head tag
// head_dest         in   5          architectural destination register
// head_value        in   XLEN       head result
// head_branch_mis   in   1          branch mispredicted (branch_result)
// head_target       in   XLEN       resolved branch target from the branch unit
// head_pc           in   XLEN       head instruction PC
// head_exception    in   1          head carries an exception
// head_mcause       in   8          exception cause
// store_ack         in   1          LSQ: head store written to memory
// store_fault       in   1          LSQ: head store access illegal
// rob_rd_en         out  1          dequeue ROB head this cycle
// illegal_access_e  out  1          mark head exception, mcause=2
// rf_we             out  1          register file write enable
// rf_waddr          out  5          register file write address
// rf_wdata          out  XLEN       register file write data
// rf_wtag           out  ROB_IDX_W  retiring tag; clears matching rename entries
// store_req         out  1          release head store to the LSQ
// flush             out  1          squash all speculative state; ORed into ROB/RS reset at top level
// redirect_valid    out  1          fetch redirect strobe
// redirect_pc       out  XLEN       fetch redirect target
// trap_valid        out  1          trap entry strobe to CSR unit
// trap_mcause       out  8          trap cause
// trap_mepc         out  XLEN       PC of the faulting instruction
// retired_count     out  32         retired instruction counter
// BEHAVIOUR
// - FSM states: RUN, STORE_WAIT, FLUSH.
// - Reset: state=RUN, retired_count=0, flush counter=0.
//   All strobes (rob_rd_en, rf_we, store_req, flush, redirect_valid, trap_valid, illegal_access_e) read 0.
//   redirect_pc, trap_* and rf_* data outputs read 0.
// - RUN with rob_empty=1: no outputs asserted.
// - RUN, head_exception=1 (checked first, regardless of head_ready):
//   - No dequeue.
//   - Latch trap_mcause=head_mcause and trap_mepc=head_pc, load counter=FLUSH_CYCLES, go to FLUSH.
//   - trap_valid pulses 1 cycle in the first FLUSH cycle.
// - RUN, itype 1x, head_ready=1: same-cycle (combinational) commit.
//   - rob_rd_en=1; rf_we=(head_dest!=0); rf_waddr=head_dest; rf_wdata=head_value; rf_wtag=head_rob_num.
//   - x0 destination: entry is still dequeued and counted.
// - RUN, itype 00, head_ready=1:
//   - Always rob_rd_en=1.
//   - If head_branch_mis=1: latch redirect_pc=head_target, go to FLUSH.
//     redirect_valid pulses in the first FLUSH cycle.
// - RUN, itype 01: store_req=1 combinationally (head_ready not required), go to STORE_WAIT.
// - STORE_WAIT: store_req held 1.
//   - On store_ack: rob_rd_en=1 in the same cycle, store_req drops next cycle, back to RUN.
//   - On store_fault: illegal_access_e=1 for 1 cycle, no dequeue, back to RUN.
//     The head exception becomes visible next cycle and traps.
//   - store_ack and store_fault together: fault wins.
//   - store_ack or store_fault seen outside STORE_WAIT: ignored.
// - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, counter decrements each cycle.
//   - No rob_rd_en, store_req or rf_we while in FLUSH.
//   - At counter=1, return to RUN.
// - retired_count increments by 1 on every cycle where rob_rd_en=1; it wraps at 2^32.
// - rob_rd_en is never asserted while rob_empty=1.
// - Reset mid-STORE_WAIT or mid-FLUSH: returns to RUN next cycle with all strobes 0; no partial commit.
// TESTING
// - ALU retire: head itype=10, ready, dest=5, value=0xDEADBEEF
//   -> same cycle rob_rd_en=1, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retired_count 0->1.
// - x0 write: itype=11, dest=0 -> rob_rd_en=1, rf_we=0, retired_count increments.
// - Store: itype=01 -> store_req=1; ack 3 cycles later
//   -> rob_rd_en=1 only in the ack cycle, store_req=0 the next cycle.
// - Mispredict: branch, head_branch_mis=1, target=0x100, FLUSH_CYCLES=2
//   -> rob_rd_en=1 that cycle, then flush=1 for 2 cycles, redirect_valid=1 with pc 0x100 in the first.
// - Store fault: store_fault in STORE_WAIT -> illegal_access_e=1 for 1 cycle.
//   Drive head_exception=1, mcause=2, pc=0x40 -> trap_valid=1, trap_mcause=2, trap_mepc=0x40, flush=1 for 2 cycles.
// - Reset asserted in STORE_WAIT -> next cycle store_req=0, state RUN; a stale store_ack causes no rob_rd_en.

Source files
------------

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement controller sitting between the ROB head and
// the architectural state. Each cycle it looks at the ROB head and either
// retires it, releases a store to the LSQ, flushes on a branch mispredict or
// enters a trap on an exception.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   rob_empty          ROB has no valid head
//   head_*             ROB head fields (ready, itype, tag, dest, value, branch
//                      outcome/target, pc, exception/mcause)
//   store_ack          LSQ wrote the head store to memory
//   store_fault        LSQ found the head store access illegal
//   rob_rd_en          dequeue the ROB head this cycle
//   illegal_access_e   tell the ROB to mark the head with mcause=2
//   rf_we/waddr/wdata  architectural register file write port
//   rf_wtag            retiring tag, clears matching rename entries
//   store_req          release the head store to the LSQ
//   flush              squash all speculative state
//   redirect_valid/pc  fetch redirect after a mispredict
//   trap_valid/mcause/mepc  trap entry request to the CSR unit
//   retired_count      free-running retired instruction counter
module commit_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ROB_IDX_W    = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rob_empty,
    input  logic                 head_ready,
    input  logic [1:0]           head_itype,
    input  logic [ROB_IDX_W-1:0] head_rob_num,
    input  logic [4:0]           head_dest,
    input  logic [XLEN-1:0]      head_value,
    input  logic                 head_branch_mis,
    input  logic [XLEN-1:0]      head_target,
    input  logic [XLEN-1:0]      head_pc,
    input  logic                 head_exception,
    input  logic [7:0]           head_mcause,
    input  logic                 store_ack,
    input  logic                 store_fault,
    output logic                 rob_rd_en,
    output logic                 illegal_access_e,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [ROB_IDX_W-1:0] rf_wtag,
    output logic                 store_req,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 trap_valid,
    output logic [7:0]           trap_mcause,
    output logic [XLEN-1:0]      trap_mepc,
    output logic [31:0]          retired_count
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        StRun,
        StStoreWait,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       retired_count_q, retired_count_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [7:0]        trap_mcause_q, trap_mcause_d;
    logic [XLEN-1:0]   trap_mepc_q, trap_mepc_d;
    logic              trap_valid_q, trap_valid_d;

    logic              rd_c;
    logic              rf_commit_c;
    logic              store_req_c;
    logic              illegal_c;
    logic              flush_c;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_pc_d    = redirect_pc_q;
        trap_mcause_d    = trap_mcause_q;
        trap_mepc_d      = trap_mepc_q;
        // Valid strobes only live for the first FLUSH cycle.
        redirect_valid_d = 1'b0;
        trap_valid_d     = 1'b0;
        rd_c             = 1'b0;
        rf_commit_c      = 1'b0;
        store_req_c      = 1'b0;
        illegal_c        = 1'b0;
        flush_c          = 1'b0;

        unique case (state_q)
            StRun: begin
                if (!rob_empty) begin
                    if (head_exception) begin
                        trap_mcause_d = head_mcause;
                        trap_mepc_d   = head_pc;
                        trap_valid_d  = 1'b1;
                        cnt_d         = FlushLoad;
                        state_d       = StFlush;
                    end else if (head_itype[1]) begin
                        if (head_ready) begin
                            rd_c        = 1'b1;
                            rf_commit_c = 1'b1;
                        end
                    end else if (head_itype[0]) begin
                        store_req_c = 1'b1;
                        state_d     = StStoreWait;
                    end else if (head_ready) begin
                        // Branches always retire; a mispredict also squashes.
                        rd_c = 1'b1;
                        if (head_branch_mis) begin
                            redirect_pc_d    = head_target;
                            redirect_valid_d = 1'b1;
                            cnt_d            = FlushLoad;
                            state_d          = StFlush;
                        end
                    end
                end
            end
            StStoreWait: begin
                store_req_c = 1'b1;
                if (store_fault) begin
                    // Fault wins over a simultaneous ack; head traps next cycle.
                    illegal_c = 1'b1;
                    state_d   = StRun;
                end else if (store_ack) begin
                    rd_c    = 1'b1;
                    state_d = StRun;
                end
            end
            StFlush: begin
                flush_c = 1'b1;
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Strobes are forced low while reset is held so nothing commits during reset.
    assign rob_rd_en        = rd_c & ~rob_empty & ~reset;
    assign rf_we            = rf_commit_c & (head_dest != 5'd0) & ~reset;
    assign rf_waddr         = (rf_commit_c && !reset) ? head_dest : 5'd0;
    assign rf_wdata         = (rf_commit_c && !reset) ? head_value : '0;
    assign rf_wtag          = (rf_commit_c && !reset) ? head_rob_num : '0;
    assign store_req        = store_req_c & ~reset;
    assign illegal_access_e = illegal_c & ~reset;
    assign flush            = flush_c & ~reset;
    assign redirect_valid   = redirect_valid_q & ~reset;
    assign trap_valid       = trap_valid_q & ~reset;
    assign redirect_pc      = redirect_pc_q;
    assign trap_mcause      = trap_mcause_q;
    assign trap_mepc        = trap_mepc_q;
    assign retired_count    = retired_count_q;

    assign retired_count_d  = retired_count_q + 32'(rob_rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StRun;
            cnt_q            <= '0;
            retired_count_q  <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            trap_mcause_q    <= '0;
            trap_mepc_q      <= '0;
            trap_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            retired_count_q  <= retired_count_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            trap_mcause_q    <= trap_mcause_d;
            trap_mepc_q      <= trap_mepc_d;
            trap_valid_q     <= trap_valid_d;
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: each step drives the ROB head, pushes the
// expected output set into a scoreboard queue, then pops and compares it just
// before the next rising edge.
module tb_commit_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            rob_empty;
    logic            head_ready;
    logic [1:0]      head_itype;
    logic [RW-1:0]   head_rob_num;
    logic [4:0]      head_dest;
    logic [XLEN-1:0] head_value;
    logic            head_branch_mis;
    logic [XLEN-1:0] head_target;
    logic [XLEN-1:0] head_pc;
    logic            head_exception;
    logic [7:0]      head_mcause;
    logic            store_ack;
    logic            store_fault;
    logic            rob_rd_en;
    logic            illegal_access_e;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [RW-1:0]   rf_wtag;
    logic            store_req;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_valid;
    logic [7:0]      trap_mcause;
    logic [XLEN-1:0] trap_mepc;
    logic [31:0]     retired_count;

    always #5 clk = ~clk;

    commit_ctrl #(
        .XLEN        (XLEN),
        .ROB_IDX_W   (RW),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rob_empty       (rob_empty),
        .head_ready      (head_ready),
        .head_itype      (head_itype),
        .head_rob_num    (head_rob_num),
        .head_dest       (head_dest),
        .head_value      (head_value),
        .head_branch_mis (head_branch_mis),
        .head_target     (head_target),
        .head_pc         (head_pc),
        .head_exception  (head_exception),
        .head_mcause     (head_mcause),
        .store_ack       (store_ack),
        .store_fault     (store_fault),
        .rob_rd_en       (rob_rd_en),
        .illegal_access_e(illegal_access_e),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .rf_wtag         (rf_wtag),
        .store_req       (store_req),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .trap_valid      (trap_valid),
        .trap_mcause     (trap_mcause),
        .trap_mepc       (trap_mepc),
        .retired_count   (retired_count)
    );

    typedef struct {
        string           tag;
        logic            rd;
        logic            we;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
        logic [RW-1:0]   wtag;
        logic            sreq;
        logic            ill;
        logic            fl;
        logic            rv;
        logic [XLEN-1:0] rpc;
        logic            tv;
        logic [7:0]      mc;
        logic [XLEN-1:0] mepc;
        logic [31:0]     ret;
    } exp_t;

    exp_t            sb[$];
    int              n_total = 0;
    int              n_pass  = 0;
    int              n_fail  = 0;
    logic [31:0]     exp_ret = 0;
    logic [XLEN-1:0] exp_rpc = 0;
    logic [7:0]      exp_mc  = 0;
    logic [XLEN-1:0] exp_mepc = 0;

    task automatic chk(input string tag, input string field, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    function automatic exp_t base(input string tag);
        exp_t e;
        e.tag   = tag;
        e.rd    = 0; e.we = 0; e.waddr = 0; e.wdata = 0; e.wtag = 0;
        e.sreq  = 0; e.ill = 0; e.fl = 0; e.rv = 0; e.tv = 0;
        e.rpc   = exp_rpc;
        e.mc    = exp_mc;
        e.mepc  = exp_mepc;
        e.ret   = exp_ret;
        return e;
    endfunction

    // Pop the oldest expectation and compare it 1 time unit before the edge.
    task automatic sample();
        exp_t e;
        #4;
        e = sb.pop_front();
        chk(e.tag, "rob_rd_en", 64'(rob_rd_en), 64'(e.rd));
        chk(e.tag, "rf_we", 64'(rf_we), 64'(e.we));
        chk(e.tag, "rf_waddr", 64'(rf_waddr), 64'(e.waddr));
        chk(e.tag, "rf_wdata", 64'(rf_wdata), 64'(e.wdata));
        chk(e.tag, "rf_wtag", 64'(rf_wtag), 64'(e.wtag));
        chk(e.tag, "store_req", 64'(store_req), 64'(e.sreq));
        chk(e.tag, "illegal", 64'(illegal_access_e), 64'(e.ill));
        chk(e.tag, "flush", 64'(flush), 64'(e.fl));
        chk(e.tag, "redirect_valid", 64'(redirect_valid), 64'(e.rv));
        chk(e.tag, "redirect_pc", 64'(redirect_pc), 64'(e.rpc));
        chk(e.tag, "trap_valid", 64'(trap_valid), 64'(e.tv));
        chk(e.tag, "trap_mcause", 64'(trap_mcause), 64'(e.mc));
        chk(e.tag, "trap_mepc", 64'(trap_mepc), 64'(e.mepc));
        chk(e.tag, "retired_count", 64'(retired_count), 64'(e.ret));
        if (e.rd) exp_ret++;
        @(negedge clk);
    endtask

    task automatic idle();
        rob_empty = 1; head_ready = 0; head_itype = 2'b10; head_rob_num = 0;
        head_dest = 0; head_value = 0; head_branch_mis = 0; head_target = 0;
        head_pc = 0; head_exception = 0; head_mcause = 0; store_ack = 0;
        store_fault = 0;
    endtask

    task automatic alu_head(input logic [4:0] d, input logic [XLEN-1:0] v,
                            input logic [RW-1:0] t, input logic [1:0] it);
        idle();
        rob_empty = 0; head_ready = 1; head_itype = it; head_dest = d;
        head_value = v; head_rob_num = t;
    endtask

    task automatic store_head();
        idle();
        rob_empty = 0; head_itype = 2'b01; head_rob_num = 4'd7;
    endtask

    initial begin
        exp_t e;
        reset = 1;
        idle();
        @(negedge clk);
        // Reset state
        e = base("reset"); sb.push_back(e); sample();
        reset = 0;

        // Empty ROB with a ready-looking head: nothing retires.
        alu_head(5'd9, 32'h1, 4'd1, 2'b10); rob_empty = 1;
        e = base("empty"); sb.push_back(e); sample();

        // ALU retire
        alu_head(5'd5, 32'hDEADBEEF, 4'd3, 2'b10);
        e = base("alu"); e.rd = 1; e.we = 1; e.waddr = 5; e.wdata = 32'hDEADBEEF;
        e.wtag = 3; sb.push_back(e); sample();

        // x0 destination: dequeued and counted, no write
        alu_head(5'd0, 32'h1234, 4'd4, 2'b11);
        e = base("x0"); e.rd = 1; e.wdata = 32'h1234; e.wtag = 4;
        sb.push_back(e); sample();

        // Store, ack three cycles after the request
        store_head();
        e = base("st_req"); e.sreq = 1; sb.push_back(e); sample();
        for (int i = 0; i < 2; i++) begin
            e = base("st_wait"); e.sreq = 1; sb.push_back(e); sample();
        end
        store_ack = 1;
        e = base("st_ack"); e.sreq = 1; e.rd = 1; sb.push_back(e); sample();
        idle();
        e = base("st_done"); sb.push_back(e); sample();

        // Correctly predicted branch: retires, no flush afterwards
        alu_head(5'd0, 32'h0, 4'd2, 2'b00);
        e = base("br_ok"); e.rd = 1; sb.push_back(e); sample();
        idle();
        e = base("br_ok_after"); sb.push_back(e); sample();

        // Mispredict: retire, then two flush cycles with redirect in the first
        alu_head(5'd0, 32'h0, 4'd2, 2'b00); head_branch_mis = 1; head_target = 32'h100;
        e = base("mis"); e.rd = 1; sb.push_back(e); sample();
        exp_rpc = 32'h100;
        alu_head(5'd6, 32'h55, 4'd8, 2'b10);
        e = base("mis_fl1"); e.fl = 1; e.rv = 1; sb.push_back(e); sample();
        e = base("mis_fl2"); e.fl = 1; sb.push_back(e); sample();
        e = base("mis_run"); e.rd = 1; e.we = 1; e.waddr = 6; e.wdata = 32'h55;
        e.wtag = 8; sb.push_back(e); sample();

        // Store fault (with simultaneous ack) then trap on the marked head
        store_head();
        e = base("sf_req"); e.sreq = 1; sb.push_back(e); sample();
        store_fault = 1; store_ack = 1;
        e = base("sf_fault"); e.sreq = 1; e.ill = 1; sb.push_back(e); sample();
        store_head(); head_exception = 1; head_mcause = 8'd2; head_pc = 32'h40;
        e = base("exc"); sb.push_back(e); sample();
        exp_mc = 8'd2; exp_mepc = 32'h40;
        idle();
        e = base("trap_fl1"); e.fl = 1; e.tv = 1; sb.push_back(e); sample();
        e = base("trap_fl2"); e.fl = 1; sb.push_back(e); sample();
        e = base("trap_done"); sb.push_back(e); sample();

        // Stale ack in RUN is ignored
        alu_head(5'd3, 32'h9, 4'd1, 2'b10); head_ready = 0; store_ack = 1;
        e = base("stale_run"); sb.push_back(e); sample();

        // Reset while in STORE_WAIT
        store_head();
        e = base("rst_st_req"); e.sreq = 1; sb.push_back(e); sample();
        reset = 1; store_ack = 1;
        e = base("rst_held"); sb.push_back(e); sample();
        exp_ret = 0; exp_rpc = 0; exp_mc = 0; exp_mepc = 0;
        reset = 0;
        alu_head(5'd3, 32'h9, 4'd1, 2'b10); head_ready = 0; store_ack = 1;
        e = base("rst_after"); sb.push_back(e); sample();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
